// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-transfer master fed by a command FIFO; returns one response per
// command in order through a two-entry response buffer.
module ahb_cmd_master #(
  parameter int AWIDTH    = 10,
  parameter int CMD_DEPTH = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AWIDTH-1:0] CMD_ADDR,
  input  logic [2:0]        CMD_SIZE,
  input  logic [31:0]       CMD_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR,
  output logic              RSP_WRITE,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              BUSY
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CMD_DEPTH);

  typedef struct packed {
    logic              is_write;
    logic [AWIDTH-1:0] addr;
    logic [2:0]        size;
    logic [31:0]       wdata;
  } cmd_t;

  typedef struct packed {
    logic        is_write;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  cmd_t              fifo_mem_q [CMD_DEPTH];
  logic [PTR_W-1:0]  fifo_wr_q, fifo_rd_q;
  logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;

  rsp_t              rsp_mem_q [2];
  logic              rsp_wr_q, rsp_rd_q;
  logic [1:0]        rsp_count_q, rsp_count_d;

  logic              dphase_q, dp_write_q;
  logic [31:0]       hwdata_q;

  logic              hold_q, hold_trans_q, hold_write_q;
  logic [AWIDTH-1:0] hold_addr_q;
  logic [2:0]        hold_size_q;

  cmd_t       head, cmd_in;
  rsp_t       rsp_new;
  logic       cmd_push, fifo_pop, rsp_push, rsp_pop;
  logic       issue_ok, aph_nonseq;
  logic [2:0] credit_sum;

  assign head   = fifo_mem_q[fifo_rd_q];
  assign cmd_in = '{is_write: CMD_WRITE, addr: CMD_ADDR, size: CMD_SIZE, wdata: CMD_WDATA};

  assign CMD_READY = (fifo_count_q < DEPTH_C);
  assign cmd_push  = CMD_VALID && CMD_READY;

  assign RSP_VALID = (rsp_count_q != 2'd0);
  assign rsp_pop   = RSP_VALID && RSP_READY;
  assign RSP_RDATA = RSP_VALID ? rsp_mem_q[rsp_rd_q].rdata    : 32'h0;
  assign RSP_ERR   = RSP_VALID ? rsp_mem_q[rsp_rd_q].err      : 1'b0;
  assign RSP_WRITE = RSP_VALID ? rsp_mem_q[rsp_rd_q].is_write : 1'b0;

  // Transfers in flight (buffered + data phase + this address phase) never exceed
  // the two response slots, so a stalled consumer can never overflow the buffer.
  assign credit_sum = {1'b0, rsp_count_q} + {2'b00, dphase_q} - {2'b00, rsp_pop};
  assign issue_ok   = (fifo_count_q != '0) && (credit_sum < 3'd2);

  // A waited address phase replays last cycle's values; otherwise the FIFO head
  // is presented directly so a queued command reaches the bus one cycle after push.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    aph_nonseq = 1'b0;
    HADDR      = '0;
    HWRITE     = 1'b0;
    HSIZE      = 3'b000;
    if (hold_q) begin
      aph_nonseq = hold_trans_q;
      HADDR      = hold_addr_q;
      HWRITE     = hold_write_q;
      HSIZE      = hold_size_q;
    end else if (issue_ok) begin
      aph_nonseq = 1'b1;
      HADDR      = head.addr;
      HWRITE     = head.is_write;
      HSIZE      = head.size;
    end
  end

  assign HTRANS    = aph_nonseq ? 2'b10 : 2'b00;
  assign fifo_pop  = aph_nonseq && HREADY;
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;

  assign rsp_push = dphase_q && HREADY;
  assign rsp_new  = '{is_write: dp_write_q, err: HRESP, rdata: (dp_write_q ? 32'h0 : HRDATA)};

  assign BUSY = (fifo_count_q != '0) || dphase_q || (rsp_count_q != 2'd0);

  always_comb begin
    fifo_count_d = fifo_count_q;
    case ({cmd_push, fifo_pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
    rsp_count_d = rsp_count_q;
    case ({rsp_push, rsp_pop})
      2'b10:   rsp_count_d = rsp_count_q + 2'd1;
      2'b01:   rsp_count_d = rsp_count_q - 2'd1;
      default: rsp_count_d = rsp_count_q;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
      fifo_count_q <= '0;
      rsp_wr_q     <= 1'b0;
      rsp_rd_q     <= 1'b0;
      rsp_count_q  <= 2'd0;
      dphase_q     <= 1'b0;
      dp_write_q   <= 1'b0;
      hwdata_q     <= 32'h0;
      hold_q       <= 1'b0;
      hold_trans_q <= 1'b0;
      hold_write_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_size_q  <= 3'b000;
    end else begin
      fifo_count_q <= fifo_count_d;
      rsp_count_q  <= rsp_count_d;
      if (cmd_push) fifo_wr_q <= fifo_wr_q + PTR_W'(1);
      if (fifo_pop) fifo_rd_q <= fifo_rd_q + PTR_W'(1);
      if (rsp_push) rsp_wr_q  <= ~rsp_wr_q;
      if (rsp_pop)  rsp_rd_q  <= ~rsp_rd_q;
      if (HREADY) begin
        dphase_q   <= aph_nonseq;
        dp_write_q <= HWRITE;
        hwdata_q   <= (aph_nonseq && HWRITE) ? head.wdata : 32'h0;
      end
      hold_q       <= !HREADY;
      hold_trans_q <= aph_nonseq;
      hold_write_q <= HWRITE;
      hold_addr_q  <= HADDR;
      hold_size_q  <= HSIZE;
    end
  end

  // NOTE: storage arrays are not reset; the pointers and counts alone define validity.
  always_ff @(posedge HCLK) begin
    if (cmd_push) fifo_mem_q[fifo_wr_q] <= cmd_in;
    if (rsp_push) rsp_mem_q[rsp_wr_q]   <= rsp_new;
  end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: latency, pipelining, wait states, ERROR,
// response back-pressure and mid-transfer reset, checked against hand-derived values.
module tb_ahb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [9:0]  CMD_ADDR;
  logic [2:0]  CMD_SIZE;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID, RSP_READY, RSP_ERR, RSP_WRITE;
  logic [31:0] RSP_RDATA;
  logic [9:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP, BUSY;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA, HRDATA;

  int checks   = 0;
  int failures = 0;

  ahb_cmd_master #(.AWIDTH(10), .CMD_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_SIZE(CMD_SIZE), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_WRITE(RSP_WRITE),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .BUSY(BUSY)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [9:0] a,
                         input logic [2:0] s, input logic [31:0] d);
    CMD_VALID = v;
    CMD_WRITE = w;
    CMD_ADDR  = a;
    CMD_SIZE  = s;
    CMD_WDATA = d;
  endtask

  initial begin
    HRESET    = 1'b1;
    RSP_READY = 1'b1;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    set_cmd(1'b0, 1'b0, 10'h0, 3'b000, 32'h0);

    // Reset state
    tick();
    tick();
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_haddr", HADDR, 10'h0);
    check("rst_hwrite", HWRITE, 1'b0);
    check("rst_hsize", HSIZE, 3'b000);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_rsp_valid", RSP_VALID, 1'b0);
    check("rst_rsp_rdata", RSP_RDATA, 32'h0);
    check("rst_rsp_err", RSP_ERR, 1'b0);
    check("rst_rsp_write", RSP_WRITE, 1'b0);
    check("rst_cmd_ready", CMD_READY, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    check("rst_hburst", HBURST, 3'b000);
    check("rst_hmastlock", HMASTLOCK, 1'b0);
    check("rst_hprot", HPROT, 4'b0011);
    HRESET = 1'b0;
    tick();

    // Single write: latency N+1 address, N+2 data, N+3 response
    set_cmd(1'b1, 1'b1, 10'h00C, 3'b010, 32'hDEADBEEF);
    tick();
    set_cmd(1'b0, 1'b0, 10'h0, 3'b000, 32'h0);
    #1;
    check("wr_htrans", HTRANS, 2'b10);
    check("wr_haddr", HADDR, 10'h00C);
    check("wr_hwrite", HWRITE, 1'b1);
    check("wr_hsize", HSIZE, 3'b010);
    check("wr_no_rsp_yet", RSP_VALID, 1'b0);
    tick();
    check("wr_hwdata", HWDATA, 32'hDEADBEEF);
    check("wr_idle_after", HTRANS, 2'b00);
    check("wr_busy", BUSY, 1'b1);
    check("wr_no_rsp_dphase", RSP_VALID, 1'b0);
    tick();
    check("wr_rsp_valid", RSP_VALID, 1'b1);
    check("wr_rsp_write", RSP_WRITE, 1'b1);
    check("wr_rsp_err", RSP_ERR, 1'b0);
    check("wr_rsp_rdata", RSP_RDATA, 32'h0);
    tick();
    check("wr_rsp_gone", RSP_VALID, 1'b0);
    check("wr_idle_busy", BUSY, 1'b0);
    check("wr_hwdata_clear", HWDATA, 32'h0);

    // Four pipelined reads, slave returns address+1
    for (int c = 0; c < 8; c++) begin
      if (c < 4) set_cmd(1'b1, 1'b0, 10'(4 * c), 3'b010, 32'h0);
      else       set_cmd(1'b0, 1'b0, 10'h0, 3'b000, 32'h0);
      HRDATA = (c >= 2 && c <= 5) ? 32'(4 * (c - 2) + 1) : 32'h0;
      #1;
      if (c >= 1 && c <= 4) begin
        check($sformatf("rd4_htrans_c%0d", c), HTRANS, 2'b10);
        check($sformatf("rd4_haddr_c%0d", c), HADDR, 64'(4 * (c - 1)));
      end else begin
        check($sformatf("rd4_htrans_c%0d", c), HTRANS, 2'b00);
      end
      if (c >= 3 && c <= 6) begin
        check($sformatf("rd4_rsp_valid_c%0d", c), RSP_VALID, 1'b1);
        check($sformatf("rd4_rdata_c%0d", c), RSP_RDATA, 64'(4 * (c - 3) + 1));
      end else begin
        check($sformatf("rd4_rsp_valid_c%0d", c), RSP_VALID, 1'b0);
      end
      tick();
    end
    HRDATA = 32'h0;
    check("rd4_busy_end", BUSY, 1'b0);

    // Write with three wait states followed by a queued read
    set_cmd(1'b1, 1'b1, 10'h020, 3'b010, 32'h11223344);
    tick();
    set_cmd(1'b1, 1'b0, 10'h024, 3'b010, 32'h0);
    #1;
    check("ws_wr_htrans", HTRANS, 2'b10);
    check("ws_wr_haddr", HADDR, 10'h020);
    tick();
    set_cmd(1'b0, 1'b0, 10'h0, 3'b000, 32'h0);
    HREADY = 1'b0;
    #1;
    check("ws_hwdata_c2", HWDATA, 32'h11223344);
    check("ws_rd_haddr_c2", HADDR, 10'h024);
    check("ws_rd_htrans_c2", HTRANS, 2'b10);
    check("ws_rd_hwrite_c2", HWRITE, 1'b0);
    tick();
    for (int w = 0; w < 3; w++) begin
      HREADY = (w == 2);
      #1;
      check($sformatf("ws_hwdata_hold%0d", w), HWDATA, 32'h11223344);
      check($sformatf("ws_haddr_hold%0d", w), HADDR, 10'h024);
      check($sformatf("ws_htrans_hold%0d", w), HTRANS, 2'b10);
      check($sformatf("ws_no_rsp%0d", w), RSP_VALID, 1'b0);
      tick();
    end
    HRDATA = 32'hCAFE0001;
    #1;
    check("ws_wr_rsp_valid", RSP_VALID, 1'b1);
    check("ws_wr_rsp_write", RSP_WRITE, 1'b1);
    check("ws_wr_rsp_err", RSP_ERR, 1'b0);
    check("ws_rd_hwdata_zero", HWDATA, 32'h0);
    check("ws_idle", HTRANS, 2'b00);
    tick();
    HRDATA = 32'h0;
    #1;
    check("ws_rd_rsp_valid", RSP_VALID, 1'b1);
    check("ws_rd_rsp_write", RSP_WRITE, 1'b0);
    check("ws_rd_rsp_rdata", RSP_RDATA, 32'hCAFE0001);
    tick();
    check("ws_rsp_done", RSP_VALID, 1'b0);

    // Two-cycle ERROR on a read, queued write completes normally
    set_cmd(1'b1, 1'b0, 10'h030, 3'b000, 32'h0);
    tick();
    set_cmd(1'b1, 1'b1, 10'h034, 3'b010, 32'h55AA55AA);
    #1;
    check("err_rd_haddr", HADDR, 10'h030);
    tick();
    set_cmd(1'b0, 1'b0, 10'h0, 3'b000, 32'h0);
    HREADY = 1'b0;
    HRESP  = 1'b1;
    #1;
    check("err_wr_htrans", HTRANS, 2'b10);
    check("err_wr_haddr", HADDR, 10'h034);
    check("err_wr_hwrite", HWRITE, 1'b1);
    tick();
    HREADY = 1'b1;
    HRDATA = 32'h0BAD0BAD;
    #1;
    check("err_wr_htrans_held", HTRANS, 2'b10);
    check("err_wr_haddr_held", HADDR, 10'h034);
    check("err_first_no_rsp", RSP_VALID, 1'b0);
    tick();
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    #1;
    check("err_wr_hwdata", HWDATA, 32'h55AA55AA);
    check("err_rd_rsp_valid", RSP_VALID, 1'b1);
    check("err_rd_rsp_err", RSP_ERR, 1'b1);
    check("err_rd_rsp_write", RSP_WRITE, 1'b0);
    check("err_rd_rsp_rdata", RSP_RDATA, 32'h0BAD0BAD);
    tick();
    check("err_wr_rsp_valid", RSP_VALID, 1'b1);
    check("err_wr_rsp_err", RSP_ERR, 1'b0);
    check("err_wr_rsp_write", RSP_WRITE, 1'b1);
    tick();
    check("err_rsp_done", RSP_VALID, 1'b0);
    check("err_busy_done", BUSY, 1'b0);

    // Response back-pressure: six reads, RSP_READY low until cycle 7
    for (int c = 0; c < 14; c++) begin
      RSP_READY = (c >= 7);
      if (c < 6) set_cmd(1'b1, 1'b0, 10'(8'h40 + 4 * c), 3'b010, 32'h0);
      else       set_cmd(1'b0, 1'b0, 10'h0, 3'b000, 32'h0);
      if (c == 2)                HRDATA = 32'h100;
      else if (c == 3)           HRDATA = 32'h101;
      else if (c >= 8 && c <= 11) HRDATA = 32'(32'h102 + (c - 8));
      else                       HRDATA = 32'h0;
      #1;
      if (c == 1 || c == 2 || (c >= 7 && c <= 10)) begin
        check($sformatf("bp_htrans_c%0d", c), HTRANS, 2'b10);
        check($sformatf("bp_haddr_c%0d", c), HADDR,
              (c <= 2) ? 64'(8'h40 + 4 * (c - 1)) : 64'(8'h48 + 4 * (c - 7)));
      end else begin
        check($sformatf("bp_htrans_c%0d", c), HTRANS, 2'b00);
      end
      if (c >= 3 && c <= 12) begin
        check($sformatf("bp_rsp_valid_c%0d", c), RSP_VALID, 1'b1);
        check($sformatf("bp_rdata_c%0d", c), RSP_RDATA,
              (c <= 7) ? 64'h100 : 64'(32'h101 + (c - 8)));
      end else begin
        check($sformatf("bp_rsp_valid_c%0d", c), RSP_VALID, 1'b0);
      end
      check($sformatf("bp_cmd_ready_c%0d", c), CMD_READY, (c == 6 || c == 7) ? 1'b0 : 1'b1);
      tick();
    end
    RSP_READY = 1'b1;
    HRDATA    = 32'h0;
    check("bp_busy_end", BUSY, 1'b0);

    // Reset during a stalled data phase with three commands queued
    set_cmd(1'b1, 1'b1, 10'h060, 3'b010, 32'h600D0001);
    tick();
    set_cmd(1'b1, 1'b0, 10'h064, 3'b010, 32'h0);
    tick();
    set_cmd(1'b1, 1'b0, 10'h068, 3'b010, 32'h0);
    HREADY = 1'b0;
    tick();
    set_cmd(1'b1, 1'b0, 10'h06C, 3'b010, 32'h0);
    tick();
    set_cmd(1'b0, 1'b0, 10'h0, 3'b000, 32'h0);
    #1;
    check("mr_busy_before", BUSY, 1'b1);
    check("mr_cmd_ready_before", CMD_READY, 1'b1);
    check("mr_htrans_before", HTRANS, 2'b10);
    check("mr_hwdata_before", HWDATA, 32'h600D0001);
    HRESET = 1'b1;
    HREADY = 1'b1;
    tick();
    HRESET = 1'b0;
    #1;
    check("mr_htrans", HTRANS, 2'b00);
    check("mr_rsp_valid", RSP_VALID, 1'b0);
    check("mr_cmd_ready", CMD_READY, 1'b1);
    check("mr_busy", BUSY, 1'b0);
    check("mr_haddr", HADDR, 10'h0);
    check("mr_hwdata", HWDATA, 32'h0);
    tick();
    check("mr_no_late_rsp", RSP_VALID, 1'b0);
    check("mr_still_idle", HTRANS, 2'b00);
    check("mr_still_not_busy", BUSY, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 Parameter AWIDTH, default 10, is the HADDR and CMD_ADDR width in bits.
REQ-002 Parameter CMD_DEPTH, default 4, is the command FIFO depth in entries (power of two, at least 2).
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high. HCLK is the clock and HRESET is the reset.
REQ-004 Port list, clock and reset first:
- HCLK  in  1  clock; all state changes on the rising edge.
- HRESET  in  1  synchronous active-high reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  FIFO has a free entry.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  AWIDTH  byte address.
- CMD_SIZE  in  3  HSIZE encoding.
- CMD_WDATA  in  32  write data.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed.
- RSP_RDATA  out  32  read data; 0 for writes.
- RSP_ERR  out  1  slave returned ERROR.
- RSP_WRITE  out  1  echo of the command's write flag.
- HADDR  out  AWIDTH  AHB address.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HWRITE  out  1  AHB write flag.
- HSIZE  out  3  AHB transfer size.
- HBURST  out  3  constant 000 (SINGLE).
- HMASTLOCK  out  1  constant 0.
- HPROT  out  4  constant 0011.
- HWDATA  out  32  data-phase write data.
- HRDATA  in  32  slave read data.
- HREADY  in  1  slave ready.
- HRESP  in  1  slave error response.
- BUSY  out  1  FIFO non-empty, data phase pending, or response held.

Function
REQ-005 Command FIFO: a command is pushed when CMD_VALID and CMD_READY are both high. CMD_READY = (fifo_count < CMD_DEPTH). A push and a pop in the same cycle while full is not allowed, because CMD_READY is low when the FIFO is full.
REQ-006 Response buffer: 2 entries. RSP_VALID = (rsp_count > 0). An entry is popped when RSP_VALID and RSP_READY are both high.
REQ-007 Address phase: when HREADY is high, the block loads HADDR/HWRITE/HSIZE from the FIFO head, drives HTRANS = NONSEQ and pops the FIFO, provided the FIFO is non-empty and the credit rule holds: rsp_count + dphase_pending + (response popped this cycle ? -1 : 0) < 2. Otherwise, when HREADY is high, HTRANS = IDLE.
REQ-008 While HREADY is low, HADDR/HTRANS/HWRITE/HSIZE hold their values and the FIFO does not pop.
REQ-009 Data phase: the cycle after an accepted NONSEQ, dphase_pending = 1. HWDATA carries the write data of that transfer and holds while HREADY is low. HWDATA is 0 for reads.
REQ-010 Completion: the data phase completes on the first cycle where dphase_pending = 1 and HREADY = 1. One response is pushed from that cycle:
- RSP_RDATA = HRDATA for reads, 0 for writes.
- RSP_ERR = HRESP.
- RSP_WRITE = the command's write flag.
REQ-011 ERROR response: the first ERROR cycle (HREADY = 0, HRESP = 1) causes no action. An already-issued next address phase is not cancelled and proceeds normally.
REQ-012 Pipelining: back-to-back transfers overlap address and data phases. With zero wait states, a full FIFO drains at one transfer per cycle while RSP_READY = 1.
REQ-013 Latency: command pushed in cycle N into an idle block → NONSEQ on the bus in N+1 → data phase in N+2 (HREADY = 1) → RSP_VALID in N+3.
REQ-014 Simultaneous events: push and pop in the same cycle leave fifo_count unchanged. Response push and pop in the same cycle leave rsp_count unchanged. The response buffer never overflows, because the credit rule in REQ-007 guarantees it.
REQ-015 Ordering: responses are returned strictly in command order.

Reset
REQ-016 HRESET high at a rising edge sets all of the following, regardless of any transfer in progress:
- fifo_count = 0, rsp_count = 0, dphase_pending = 0.
- HTRANS = 00, HADDR = 0, HWRITE = 0, HSIZE = 000, HWDATA = 0.
- RSP_VALID = 0, RSP_RDATA = 0, RSP_ERR = 0, RSP_WRITE = 0.
- CMD_READY = 1, BUSY = 0.
- Constants remain HBURST = 000, HMASTLOCK = 0, HPROT = 0011.
REQ-017 Reset mid-operation discards queued commands and pending responses. There is no response for an aborted data phase.

Verification
REQ-018 Write 0x0C, data 0xDEADBEEF, size 010, HREADY tied 1 → NONSEQ at N+1 with HADDR = 0x0C; HWDATA = 0xDEADBEEF at N+2; response at N+3 with RSP_WRITE = 1 and RSP_ERR = 0.
REQ-019 Four reads to 0x00, 0x04, 0x08, 0x0C, with the slave returning address+1 and RSP_READY = 1 → four consecutive NONSEQ cycles; RSP_RDATA = 0x01, 0x05, 0x09, 0x0D in order.
REQ-020 Slave inserts 3 wait states on a write → HWDATA and the next HADDR are held for 3 cycles; exactly one response is produced.
REQ-021 Slave returns ERROR on a read (HREADY 0/HRESP 1, then HREADY 1/HRESP 1) → RSP_ERR = 1 for that read; the following queued write still completes with RSP_ERR = 0.
REQ-022 RSP_READY held 0 with 4 commands queued → exactly 2 responses are buffered, HTRANS stays IDLE after that, CMD_READY = 1 once the FIFO drops below 4; raising RSP_READY resumes issue.
REQ-023 HRESET asserted during a data phase with 3 commands queued → next cycle HTRANS = 00, RSP_VALID = 0, CMD_READY = 1, BUSY = 0.
